// File: rtl/logic_unit_arb.sv
`default_nettype none
// ============================================================================
//  Module   : logic_unit_arb
//  Brief    : Round-robin arbiter sharing one bitwise logic unit
//             (AND/OR/XOR/NOR) among NREQ requesters, with a registered
//             result returned under a valid/ready handshake.
//  Options  : LU_ARB_ZERO_FLAG_EN adds the registered rsp_zero output.
//  Revision : 1.0 - initial release
// ============================================================================
module logic_unit_arb #(
   parameter int WIDTH = 32,
   parameter int NREQ  = 4,
   parameter int IDW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [2*NREQ-1:0]     req_op,
   input  logic [WIDTH*NREQ-1:0] req_a,
   input  logic [WIDTH*NREQ-1:0] req_b,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [WIDTH-1:0]      rsp_data,
   output logic [IDW-1:0]        rsp_id
`ifdef LU_ARB_ZERO_FLAG_EN
   ,
   output logic                  rsp_zero
`endif
);

   localparam logic [0:0] c_st_idle = 1'b0;
   localparam logic [0:0] c_st_busy = 1'b1;

   logic [0:0]       r_state;
   logic [0:0]       w_state_nxt;
   logic [IDW-1:0]   r_rr_ptr;
   logic [WIDTH-1:0] r_data;
   logic [IDW-1:0]   r_id;

   logic [NREQ-1:0]  w_rot;
   logic [IDW-1:0]   w_off;
   logic             w_any;
   logic [IDW:0]     w_sum;
   logic [IDW-1:0]   w_grant;
   logic [IDW-1:0]   w_ptr_nxt;
   logic             w_can_accept;
   logic             w_accept;
   logic [1:0]       w_op;
   logic [WIDTH-1:0] w_a;
   logic [WIDTH-1:0] w_b;
   logic [WIDTH-1:0] w_result;

   // Rotate req_valid so that bit 0 corresponds to the requester at rr_ptr
   always_comb begin
      w_rot = '0;
      for (int p = 0; p < NREQ; p++) begin
         if (r_rr_ptr == IDW'(p)) begin
            for (int k = 0; k < NREQ; k++) begin
               w_rot[k] = req_valid[(p + k) % NREQ];
            end
         end
      end
   end

   // Find the lowest set bit of the rotated vector (descending scan, last hit wins)
   always_comb begin
      w_any = 1'b0;
      w_off = '0;
      for (int j = NREQ - 1; j >= 0; j--) begin
         if (w_rot[j]) begin
            w_any = 1'b1;
            w_off = IDW'(j);
         end
      end
   end

   // Map the rotated offset back to an absolute requester index, modulo NREQ
   assign w_sum     = {1'b0, r_rr_ptr} + {1'b0, w_off};
   assign w_grant   = (w_sum >= (IDW+1)'(NREQ)) ? IDW'(w_sum - (IDW+1)'(NREQ))
                                                : w_sum[IDW-1:0];
   assign w_ptr_nxt = (w_grant == IDW'(NREQ - 1)) ? '0 : w_grant + IDW'(1);

   assign w_can_accept = (r_state == c_st_idle) || rsp_ready;
   assign w_accept     = w_any && w_can_accept;
   assign req_ready    = w_accept ? ({{(NREQ-1){1'b0}}, 1'b1} << w_grant) : '0;

   // Operand mux: pick the granted requester's opcode and operands
   always_comb begin
      w_op = 2'b00;
      w_a  = '0;
      w_b  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_grant == IDW'(i)) begin
            w_op = req_op[2*i +: 2];
            w_a  = req_a[WIDTH*i +: WIDTH];
            w_b  = req_b[WIDTH*i +: WIDTH];
         end
      end
   end

   // Shared bitwise logic slice
   always_comb begin
      case (w_op)
         2'b00:   w_result = w_a & w_b;
         2'b01:   w_result = w_a | w_b;
         2'b10:   w_result = w_a ^ w_b;
         default: w_result = ~(w_a | w_b);
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next state: accept fills the result register, a consumed result with no new accept empties it
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_idle: if (w_accept) w_state_nxt = c_st_busy;
         default: begin
            if (w_accept)       w_state_nxt = c_st_busy;
            else if (rsp_ready) w_state_nxt = c_st_idle;
         end
      endcase
   end

   // FSM output: result is valid exactly while the register is full
   always_comb begin
      rsp_valid = (r_state == c_st_busy);
   end

   // Result register and round-robin pointer update on accept only
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data   <= '0;
         r_id     <= '0;
         r_rr_ptr <= '0;
      end else if (w_accept) begin
         r_data   <= w_result;
         r_id     <= w_grant;
         r_rr_ptr <= w_ptr_nxt;
      end
   end

   assign rsp_data = r_data;
   assign rsp_id   = r_id;

`ifdef LU_ARB_ZERO_FLAG_EN
   logic r_zero;

   // Zero flag captured alongside the result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_zero <= 1'b1;
      end else if (w_accept) begin
         r_zero <= (w_result == '0);
      end
   end

   assign rsp_zero = r_zero;
`endif

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_logic_unit_arb
//  Brief    : Self-checking bench for logic_unit_arb (NREQ=4, WIDTH=32).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_logic_unit_arb;

   logic          clk;
   logic          rst_n;
   logic [3:0]    req_valid;
   logic [3:0]    req_ready;
   logic [7:0]    req_op;
   logic [127:0]  req_a;
   logic [127:0]  req_b;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [31:0]   rsp_data;
   logic [1:0]    rsp_id;
`ifdef LU_ARB_ZERO_FLAG_EN
   logic          rsp_zero;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic_unit_arb #(.WIDTH(32), .NREQ(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id)
`ifdef LU_ARB_ZERO_FLAG_EN
      ,
      .rsp_zero  (rsp_zero)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          idx;
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int i, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      req_op[2*i +: 2] = op;
      req_a[32*i +: 32] = a;
      req_b[32*i +: 32] = b;
   endtask

   initial begin
      vecs[0] = '{2, 2'b01, 32'h0F0F0000, 32'h0000F0F0, 32'h0F0FF0F0};
      vecs[1] = '{0, 2'b00, 32'hFFFF0000, 32'hFF00FF00, 32'hFF000000};
      vecs[2] = '{0, 2'b01, 32'hFFFF0000, 32'hFF00FF00, 32'hFFFFFF00};
      vecs[3] = '{0, 2'b10, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00};
      vecs[4] = '{0, 2'b11, 32'hFFFF0000, 32'hFF00FF00, 32'h000000FF};
      vecs[5] = '{3, 2'b10, 32'h12345678, 32'h12345678, 32'h00000000};
      vecs[6] = '{1, 2'b11, 32'h00000000, 32'h00000000, 32'hFFFFFFFF};
      vecs[7] = '{1, 2'b00, 32'hDEADBEEF, 32'hFFFF0000, 32'hDEAD0000};

      rst_n = 1'b0; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
      step(); step();
      @(negedge clk);
      rst_n = 1'b1;
      #1;

      // Reset state
      chk("reset_valid", 32'(rsp_valid), 32'd0);
      chk("reset_data", rsp_data, 32'd0);
      chk("reset_id", 32'(rsp_id), 32'd0);
      chk("reset_ready", 32'(req_ready), 32'd0);
`ifdef LU_ARB_ZERO_FLAG_EN
      chk("reset_zero", 32'(rsp_zero), 32'd1);
`endif

      // Single OR from requester 2, pointer must then sit at 3
      step();
      drive(2, 2'b01, 32'h0F0F0000, 32'h0000F0F0);
      req_valid = 4'b0100;
      #1;
      chk("or_ready", 32'(req_ready), 32'b0100);
      step();
      chk("or_valid", 32'(rsp_valid), 32'd1);
      chk("or_data", rsp_data, 32'h0F0FF0F0);
      chk("or_id", 32'(rsp_id), 32'd2);
      req_valid = 4'b1111;
      #1;
      chk("ptr_after_or", 32'(req_ready), 32'b1000);
      req_valid = 4'b0000;

      // Table of single-request vectors
      for (int v = 0; v < 8; v++) begin
         drive(vecs[v].idx, vecs[v].op, vecs[v].a, vecs[v].b);
         req_valid = 4'b0001 << vecs[v].idx;
         #1;
         chk($sformatf("vec%0d_ready", v), 32'(req_ready), 32'(4'b0001 << vecs[v].idx));
         step();
         req_valid = 4'b0000;
         chk($sformatf("vec%0d_valid", v), 32'(rsp_valid), 32'd1);
         chk($sformatf("vec%0d_data", v), rsp_data, vecs[v].exp);
         chk($sformatf("vec%0d_id", v), 32'(rsp_id), 32'(vecs[v].idx));
      end

      // Backpressure: hold result while rsp_ready is low, then drain+accept together
      drive(0, 2'b00, 32'hF0F0F0F0, 32'hFF00FF00);
      req_valid = 4'b0001;
      step();
      chk("bp_fill_data", rsp_data, 32'hF000F000);
      rsp_ready = 1'b0;
      drive(2, 2'b01, 32'h00000001, 32'h00000002);
      req_valid = 4'b0100;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk($sformatf("bp%0d_ready", c), 32'(req_ready), 32'd0);
         step();
         chk($sformatf("bp%0d_valid", c), 32'(rsp_valid), 32'd1);
         chk($sformatf("bp%0d_data", c), rsp_data, 32'hF000F000);
         chk($sformatf("bp%0d_id", c), 32'(rsp_id), 32'd0);
      end
      rsp_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(req_ready), 32'b0100);
      step();
      req_valid = 4'b0000;
      chk("bp_new_data", rsp_data, 32'h00000003);
      chk("bp_new_id", 32'(rsp_id), 32'd2);
      chk("bp_new_valid", 32'(rsp_valid), 32'd1);
      step();
      chk("drain_valid", 32'(rsp_valid), 32'd0);
      chk("drain_hold_data", rsp_data, 32'h00000003);
      chk("drain_hold_id", 32'(rsp_id), 32'd2);

      // Asynchronous reset while BUSY
      drive(1, 2'b01, 32'h00000005, 32'h00000000);
      req_valid = 4'b0010;
      step();
      req_valid = 4'b0000;
      rsp_ready = 1'b0;
      chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(rsp_valid), 32'd0);
      chk("arst_data", rsp_data, 32'd0);
      chk("arst_id", 32'(rsp_id), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      step();

      // Fairness from reset: every requester valid, grants 0,1,2,3,0,1,2,3
      for (int i = 0; i < 4; i++) drive(i, 2'b01, 32'h1 << i, 32'h0);
      req_valid = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         #1;
         chk($sformatf("rr%0d_ready", k), 32'(req_ready), 32'(4'b0001 << (k % 4)));
         step();
         chk($sformatf("rr%0d_valid", k), 32'(rsp_valid), 32'd1);
         chk($sformatf("rr%0d_id", k), 32'(rsp_id), 32'(k % 4));
         chk($sformatf("rr%0d_data", k), rsp_data, 32'h1 << (k % 4));
      end
      req_valid = 4'b0000;
      step();

`ifdef LU_ARB_ZERO_FLAG_EN
      // Zero flag follows each accepted result
      drive(0, 2'b00, 32'hAAAAAAAA, 32'h55555555);
      req_valid = 4'b0001;
      step();
      chk("zf_and_data", rsp_data, 32'h0);
      chk("zf_and_zero", 32'(rsp_zero), 32'd1);
      drive(1, 2'b01, 32'hAAAAAAAA, 32'h55555555);
      req_valid = 4'b0010;
      step();
      req_valid = 4'b0000;
      chk("zf_or_data", rsp_data, 32'hFFFFFFFF);
      chk("zf_or_zero", 32'(rsp_zero), 32'd0);
      step();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
